// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding, datapath width and step count.
package mdu_pkg;

    localparam int MDU_N     = 32;
    localparam int MDU_STEPS = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    // Two's-complement negate used for magnitudes and sign fix-up.
    function automatic logic [MDU_N-1:0] mdu_neg(
        input logic [MDU_N-1:0] v
    );
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the control unit and the MDU.
// master: start/op/A/B out, busy/done/result/zero in; slave: reverse.
interface mdu_iter_if;
    import mdu_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [MDU_N-1:0] A;
    logic [MDU_N-1:0] B;
    logic             busy;
    logic             done;
    logic [MDU_N-1:0] result;
    logic             zero;

    modport master (
        output start, op, A, B,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, result, zero
    );

endinterface

// File: rtl/mdu_iter_rca.sv
// Ripple-carry adder: o_sum = i_a + i_b + i_cin, carry out on o_cout.
// Ports: i_a, i_b (N), i_cin (1), o_sum (N), o_cout (1).
module rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    always_comb begin
        logic c;
        c     = i_cin;
        o_sum = '0;
        for (int i = 0; i < N; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
        o_cout = c;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide, 33-cycle latency.
// Ports: clk, rst (sync, active high), bus (slave: start/op/A/B -> busy/done/result/zero).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int N = MDU_N
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);

    mdu_state_t     r_state;
    logic [5:0]     r_cnt;
    logic [2:0]     r_op;
    logic           r_neg_a;
    logic           r_neg_b;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_opb;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_result;
    logic           r_zero;

    logic           w_accept;
    logic           w_sgn_a;
    logic           w_sgn_b;
    logic           w_neg_a;
    logic           w_neg_b;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_div;
    logic [N-1:0]   w_shift;
    logic [N-1:0]   w_add_a;
    logic [N-1:0]   w_add_b;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic           w_fit;
    logic [N-1:0]   w_acc_n;
    logic [N-1:0]   w_lo_n;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_prod_s;
    logic [N-1:0]   w_quo_s;
    logic [N-1:0]   w_rem_s;
    logic           w_dz;
    logic [N-1:0]   w_res;

    // Accept / operand conditioning
    assign w_accept = bus.start && (r_state != MDU_BUSY);

    assign w_sgn_a = (bus.op == MDU_MULH) || (bus.op == MDU_MULHSU)
                  || (bus.op == MDU_DIV)  || (bus.op == MDU_REM);
    assign w_sgn_b = (bus.op == MDU_MULH) || (bus.op == MDU_DIV)
                  || (bus.op == MDU_REM);

    assign w_neg_a = w_sgn_a & bus.A[N-1];
    assign w_neg_b = w_sgn_b & bus.B[N-1];
    assign w_mag_a = w_neg_a ? mdu_neg(bus.A) : bus.A;
    assign w_mag_b = w_neg_b ? mdu_neg(bus.B) : bus.B;

    // One shared adder: multiply adds the multiplicand,
    // divide adds ~divisor + 1 to the shifted partial remainder.
    assign w_div   = r_op[2];
    assign w_shift = {r_acc[N-2:0], r_lo[N-1]};
    assign w_add_a = w_div ? w_shift : r_acc;
    assign w_add_b = w_div ? ~r_opb : (r_lo[0] ? r_opb : '0);

    rca #(.N(N)) u_rca (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_div),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    // The shifted remainder is really N+1 bits; its lost MSB
    // means it already exceeds any divisor.
    assign w_fit = r_acc[N-1] | w_cout;

    always_comb begin
        w_acc_n = r_acc;
        w_lo_n  = r_lo;
        if (w_div) begin
            w_acc_n = w_fit ? w_sum : w_shift;
            w_lo_n  = {r_lo[N-2:0], w_fit};
        end else begin
            w_acc_n = {w_cout, w_sum[N-1:1]};
            w_lo_n  = {w_sum[0], r_lo[N-1:1]};
        end
    end

    // Result formation from the post-step values
    assign w_prod   = {w_acc_n, w_lo_n};
    assign w_prod_s = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = (r_neg_a ^ r_neg_b) ? mdu_neg(w_lo_n) : w_lo_n;
    assign w_rem_s  = r_neg_a ? mdu_neg(w_acc_n) : w_acc_n;
    assign w_dz     = (r_opb == '0);

    always_comb begin
        w_res = '0;
        unique case (r_op)
            MDU_MUL:    w_res = w_prod_s[N-1:0];
            MDU_MULH,
            MDU_MULHSU,
            MDU_MULHU:  w_res = w_prod_s[2*N-1:N];
            MDU_DIV,
            MDU_DIVU:   w_res = w_dz ? '1 : w_quo_s;
            default:    w_res = w_rem_s;
        endcase
    end

    // The first BUSY cycle only loads; r_busy rises with the
    // first real step so 32 steps land exactly at edge k+33.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_op     <= MDU_MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MDU_BUSY: begin
                    if (r_busy) begin
                        r_acc <= w_acc_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(MDU_STEPS - 1)) begin
                            r_state  <= MDU_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                        end
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= MDU_BUSY;
                        r_op    <= bus.op;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_acc   <= '0;
                        r_lo    <= bus.op[2] ? w_mag_a : w_mag_b;
                        r_opb   <= bus.op[2] ? w_mag_b : w_mag_a;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= MDU_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit implementing the RV32M operations beside the combinational ALU in the single-cycle RISC-V datapath. It accepts two 32-bit operands and a 3-bit funct3 op on a start pulse. It computes with a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop. It returns a 32-bit result plus a zero flag after a fixed latency. The control unit stalls the PC while `busy` is high.

## Interface
- `N`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE or DONE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  N  rs1 operand (dividend / multiplicand).
- `B`  in  N  rs2 operand (divisor / multiplier).
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  N  operation result; held until the next accepted start.
- `zero`  out  1  `result == 0`; registered with `result`.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE --start--> BUSY.
  - BUSY --count==31 step--> DONE.
  - DONE --start--> BUSY.
  - DONE --no start--> IDLE.
- On accept, latch `op`, the sign flags, and the operand magnitudes, then clear the 6-bit step counter.
  - Signed operands use two's-complement magnitude: DIV/REM/MULH take A and B signed; MULHSU takes only A signed.
- Multiply: 64-bit product register. Each BUSY cycle adds the multiplicand when the multiplier LSB is 1, then shifts right.
  - MUL returns product[31:0].
  - MULH/MULHSU/MULHU return product[63:32]. For MULH/MULHSU, negate the full 64-bit product when exactly one operand was negative.
- Divide: restoring algorithm on magnitudes, one quotient bit per cycle.
  - Quotient is negated iff the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A unchanged.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Special cases still take the full latency.
- `start` while BUSY is ignored, and latched operands are unaffected. A `start` in the DONE cycle is accepted, giving back-to-back operation.
- `A`, `B`, and `op` may change freely after the accept cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `zero` 1, counter 0.
- If `start` is sampled at edge k:
  - `busy` is 1 from edge k+1 through edge k+32.
  - `done` and a valid `result`/`zero` appear after edge k+33.
  - Latency is 33 cycles for every op.
- `done` is high for exactly one cycle. `result` and `zero` are updated only at the edge that sets `done`.
- Reset asserted mid-operation aborts the operation. The next cycle shows reset values and no `done` pulse.
- `start` together with `rst`: reset wins and the request is dropped.

## Structure
- Package `mdu_pkg`:
  - funct3 localparams `MDU_MUL` … `MDU_REMU`.
  - state encoding `MDU_IDLE`/`MDU_BUSY`/`MDU_DONE`.
  - `MDU_STEPS = 32`.
- Sub-module: the existing `rca` ripple-carry adder, instantiated once at width N for the per-step add/subtract.
  - Subtraction is formed as A + (~B + 1), the same convention the ALU uses.
  - Final sign correction uses a separate negate expression, not a second adder.
- Remaining logic in one file: FSM, counter, shift registers, result mux.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) -> `result` 0xFFFFFFEB, `done` exactly 33 cycles after start, `zero` 0.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. Overflow: DIV 0x80000000 / −1 -> 0x80000000; REM same operands -> 0 with `zero` 1.
- Changing `A`/`B` and pulsing `start` while busy -> ignored, and the original result is delivered. `start` in the DONE cycle -> second result exactly 33 cycles later.
- Assert `rst` at cycle 10 of a DIV -> `busy` 0, `result` 0, `zero` 1 next cycle. No `done` appears within the next 40 cycles without a new start.
